// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, defaults and entry-width helper for the fetch queue
package fetch_pkg;

    typedef enum logic {FQ_RUN, FQ_HALTED} fq_state_e;

    localparam int FQ_INSTR_BYTES = 2;

    function automatic int fq_entry_w(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {pc, instr} entries with synchronous flush
module fetch_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    always_ff @(posedge clk)
        if (push && !flush) mem[wp] <= din;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    assign dout = mem[rp];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with prefetch queue, redirect squash, halt and error flag
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = FQ_INSTR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc2,
    output logic              err
);

    localparam int                CW    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);
    localparam logic [CW:0]       LIMIT = (CW+1)'(DEPTH);

    typedef logic [fq_entry_w(ADDR_W, DATA_W)-1:0] entry_t;

    fq_state_e         state;
    fq_state_e         state_nxt;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] rpc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic              accept;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              rsp_bad;
    logic              push;
    logic              pop;
    entry_t            head;

    // Squashed requests are always the oldest, so they are retired before live ones.
    assign rsp_drop = imem_rsp_valid && drop != '0;
    assign rsp_keep = imem_rsp_valid && drop == '0 && inflight != '0;
    assign rsp_bad  = imem_rsp_valid && drop == '0 && inflight == '0;

    assign imem_req_valid = state == FQ_RUN && !redirect_valid &&
                            ({1'b0, count} + {1'b0, inflight} + {1'b0, drop} < LIMIT);
    assign imem_addr      = fpc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign push      = rsp_keep && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_valid = count != '0;
    assign out_pc    = head[DATA_W +: ADDR_W];
    assign out_instr = head[DATA_W-1:0];
    assign out_pc2   = out_pc + STEP;

    always_comb
        state_nxt = redirect_valid ? FQ_RUN : (halt ? FQ_HALTED : state);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= FQ_RUN;
        else state <= state_nxt;

    // Live requests were issued at consecutive PCs, so rpc tracks the PC of the next kept response.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fpc      <= RESET_PC;
            rpc      <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            err      <= 1'b0;
        end else begin
            err <= err | rsp_bad;
            if (redirect_valid) begin
                fpc      <= redirect_pc;
                rpc      <= redirect_pc;
                inflight <= '0;
                drop     <= drop + inflight - CW'(rsp_drop || rsp_keep);
            end else begin
                if (accept) fpc <= fpc + STEP;
                if (rsp_keep) rpc <= rpc + STEP;
                inflight <= inflight + CW'(accept) - CW'(rsp_keep);
                drop     <= drop - CW'(rsp_drop);
            end
        end

    fetch_fifo #(
        .W     (fq_entry_w(ADDR_W, DATA_W)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({rpc, imem_rsp_data}),
        .dout  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed phases plus randomized traffic against a queue-based reference model
module tb_fetch_queue;

    typedef struct {
        logic [15:0] addr;
        bit          live;
        int          due;
    } req_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc2;
    logic        err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_pct, ordy_pct, rsp_pct, lat_min, lat_max;
    int dut_pops, dut_accs, exp_out;
    bit force_rsp;

    req_t        mq[$];
    ent_t        oq[$];
    logic [15:0] fpc;
    bit          halted;
    bit          err_m;
    logic        last_ov;
    logic [15:0] last_pc;
    logic [15:0] last_pc2;

    fetch_queue #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .DEPTH       (4),
        .RESET_PC    (16'h0000),
        .INSTR_BYTES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc2        (out_pc2),
        .err            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic knobs(input int r, input int o, input int s, input int lmin, input int lmax);
        rdy_pct = r;
        ordy_pct = o;
        rsp_pct = s;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        force_rsp = 1'b0;
        mq.delete();
        oq.delete();
        fpc = 16'h0000;
        halted = 1'b0;
        err_m = 1'b0;
        #2;
        chk("rst_async_out_valid", out_valid, 1'b0);
        chk("rst_async_err", err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: drive memory/decode, check outputs at negedge, then advance the model.
    task automatic step();
        req_t        e;
        logic        exp_rv;
        logic        acc;
        logic        popv;
        logic [15:0] p2;
        imem_rsp_valid = force_rsp;
        imem_rsp_data = 16'hdead;
        if (!force_rsp && mq.size() > 0)
            if (mq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mq[0].addr ^ 16'h5a3c;
            end
        imem_req_ready = $urandom_range(99) < rdy_pct;
        out_ready = $urandom_range(99) < ordy_pct;
        @(negedge clk);
        exp_rv = !halted && !redirect_valid && (oq.size() + mq.size() < 4);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("imem_addr", imem_addr, fpc);
        chk("out_valid", out_valid, oq.size() > 0);
        if (oq.size() > 0) begin
            p2 = oq[0].pc + 16'd2;
            chk("out_pc", out_pc, oq[0].pc);
            chk("out_instr", out_instr, oq[0].instr);
            chk("out_pc2", out_pc2, p2);
        end
        chk("err", err, err_m);
        last_ov = out_valid;
        last_pc = out_pc;
        last_pc2 = out_pc2;
        if (out_valid && out_ready) dut_pops++;
        if (imem_req_valid && imem_req_ready) dut_accs++;
        acc = exp_rv && imem_req_ready;
        popv = oq.size() > 0 && out_ready;
        if (redirect_valid) oq.delete();
        else if (popv) oq.delete(0);
        if (imem_rsp_valid) begin
            if (mq.size() == 0) err_m = 1'b1;
            else begin
                e = mq.pop_front();
                if (e.live && !redirect_valid) oq.push_back('{e.addr, imem_rsp_data});
            end
        end
        if (redirect_valid) begin
            foreach (mq[i]) mq[i].live = 1'b0;
            fpc = redirect_pc;
            halted = 1'b0;
        end else begin
            if (acc) begin
                mq.push_back('{fpc, 1'b1, cyc + $urandom_range(lat_max, lat_min)});
                fpc = fpc + 16'd2;
            end
            if (halt) halted = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int lim);
        int n = 0;
        step();
        while (!last_ov && n < lim) begin
            step();
            n++;
        end
        chk("wait_out_valid", last_ov, 1'b1);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 16'h0000;
        out_ready = 1'b0;
        force_rsp = 1'b0;
        knobs(100, 100, 100, 1, 1);
        @(posedge clk);
        do_reset();

        // free run at full throughput
        dut_pops = 0;
        repeat (20) step();
        chk("freerun_pops", dut_pops, 18);

        // decode stall fills exactly DEPTH entries
        do_reset();
        knobs(100, 0, 100, 1, 1);
        dut_accs = 0;
        repeat (10) step();
        chk("stall_accs", dut_accs, 4);
        chk("stall_head_pc", last_pc, 16'h0000);
        knobs(100, 100, 100, 1, 1);
        dut_pops = 0;
        repeat (8) step();
        chk("stall_drain", dut_pops >= 4, 1'b1);

        // redirect with requests in flight at latency 3
        do_reset();
        knobs(100, 100, 100, 3, 3);
        repeat (3) step();
        redirect_to(16'h0100);
        wait_out(20);
        chk("redirect_first_pc", last_pc, 16'h0100);
        repeat (12) step();

        // PC wrap
        knobs(100, 100, 100, 1, 1);
        redirect_to(16'hfffe);
        wait_out(20);
        chk("wrap_pc", last_pc, 16'hfffe);
        chk("wrap_pc2", last_pc2, 16'h0000);
        step();
        chk("wrap_next_valid", last_ov, 1'b1);
        chk("wrap_next_pc", last_pc, 16'h0000);

        // halt drains outstanding work, then stays halted until redirect
        do_reset();
        knobs(100, 100, 100, 2, 2);
        repeat (3) step();
        halt = 1'b1;
        step();
        exp_out = oq.size() + mq.size();
        dut_pops = 0;
        dut_accs = 0;
        repeat (12) step();
        chk("halt_outputs", dut_pops, exp_out);
        chk("halt_no_issue", dut_accs, 0);
        halt = 1'b0;
        repeat (5) step();
        chk("unhalt_no_issue", dut_accs, 0);
        redirect_to(16'h0040);
        wait_out(20);
        chk("resume_pc", last_pc, 16'h0040);

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0)
                knobs($urandom_range(100, 20), $urandom_range(100, 10), $urandom_range(100, 30),
                      1, $urandom_range(4, 1));
            redirect_valid = $urandom_range(99) < 4;
            redirect_pc = 16'($urandom) & 16'hfffe;
            halt = $urandom_range(99) < 3;
            if (i == 800) do_reset();
            step();
        end
        redirect_valid = 1'b0;
        halt = 1'b0;

        // unsolicited response with nothing outstanding
        knobs(100, 0, 100, 1, 2);
        halt = 1'b1;
        for (int n = 0; n < 60 && !(halted && mq.size() == 0); n++) step();
        chk("drain_outstanding", mq.size(), 0);
        force_rsp = 1'b1;
        step();
        force_rsp = 1'b0;
        repeat (5) step();
        chk("err_sticky", err, 1'b1);
        do_reset();
        step();
        chk("err_cleared", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
